// File: rtl/baud_cfg_ctrl_pkg.sv
// baud_cfg_ctrl_pkg: shared state encoding and autobaud arithmetic constants
package baud_cfg_ctrl_pkg;

    typedef enum logic [2:0] {
        IDLE,
        WAIT_IDLE,
        WAIT_FALL,
        MEAS_LOW,
        MEAS_HIGH,
        CALC,
        APPLY
    } state_t;

    // One bit period spans OVERSAMPLE generator ticks.
    localparam int OVERSAMPLE = 16;
    localparam int OVS_SHIFT  = $clog2(OVERSAMPLE);
    localparam int ROUND      = OVERSAMPLE / 2;

    // Low/high bit lengths may differ by at most L/2^TOL_SHIFT.
    localparam int TOL_SHIFT  = 3;

endpackage

// File: rtl/baud_cfg_ctrl_if.sv
// baud_cfg_ctrl_if: host/line inputs and generator-side outputs of the baud controller
interface baud_cfg_ctrl_if #(
    parameter int FINAL_VALUE_BITS = 10
);
    logic                        rx_in;
    logic                        auto_start;
    logic                        host_wr;
    logic [FINAL_VALUE_BITS-1:0] host_value;
    logic [FINAL_VALUE_BITS-1:0] final_value;
    logic                        gen_rst_n;
    logic                        cfg_update;
    logic                        busy;
    logic                        locked;
    logic                        err;

    modport master (
        output rx_in, auto_start, host_wr, host_value,
        input  final_value, gen_rst_n, cfg_update, busy, locked, err
    );

    modport slave (
        input  rx_in, auto_start, host_wr, host_value,
        output final_value, gen_rst_n, cfg_update, busy, locked, err
    );

endinterface

// File: rtl/baud_cfg_ctrl_sync_2ff.sv
// baud_cfg_ctrl_sync_2ff: two-flop synchronizer with edge detect on the synchronized level
module baud_cfg_ctrl_sync_2ff (
    input  logic clk,
    input  logic reset,
    input  logic d,
    output logic q,
    output logic rise,
    output logic fall
);

    logic s1_q, s1_d;
    logic s2_q, s2_d;
    logic prev_q, prev_d;

    // Shift the raw line through two stages, then keep one more copy for edge detection.
    always_comb begin
        s1_d   = d;
        s2_d   = s1_q;
        prev_d = s2_q;
    end

    // Reset to the idle-high line level so no false falling edge appears after reset.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            s1_q   <= 1'b1;
            s2_q   <= 1'b1;
            prev_q <= 1'b1;
        end else begin
            s1_q   <= s1_d;
            s2_q   <= s2_d;
            prev_q <= prev_d;
        end
    end

    assign q    = s2_q;
    assign rise = s2_q & ~prev_q;
    assign fall = ~s2_q & prev_q;

endmodule

// File: rtl/baud_cfg_ctrl.sv
// baud_cfg_ctrl: selects the baud generator FINAL_VALUE from host writes or 0x55 autobaud
module baud_cfg_ctrl
    import baud_cfg_ctrl_pkg::*;
#(
    parameter int FINAL_VALUE_BITS = 10,
    parameter int DEFAULT_VALUE    = 324,
    parameter int MIN_FINAL        = 1,
    parameter int CNT_BITS         = FINAL_VALUE_BITS + 5
) (
    input  logic           clk,
    input  logic           reset,
    baud_cfg_ctrl_if.slave bus
);

    localparam logic [FINAL_VALUE_BITS-1:0] DEFAULT_FV = FINAL_VALUE_BITS'(DEFAULT_VALUE);
    localparam logic [CNT_BITS-1:0] CNT_MAX = '1;
    localparam logic [CNT_BITS-1:0] FV_MAX  = CNT_BITS'((1 << FINAL_VALUE_BITS) - 1);
    localparam logic [CNT_BITS-1:0] FV_MIN  = CNT_BITS'(MIN_FINAL);

    state_t                      state_q, state_d;
    logic [CNT_BITS-1:0]         l_q, l_d;
    logic [CNT_BITS-1:0]         h_q, h_d;
    logic [FINAL_VALUE_BITS-1:0] final_q, final_d;
    logic                        gen_rst_n_q, gen_rst_n_d;
    logic                        cfg_update_q, cfg_update_d;
    logic                        busy_q, busy_d;
    logic                        locked_q, locked_d;
    logic                        err_q, err_d;

    logic                        rx, rx_rise, rx_fall;
    logic [CNT_BITS-1:0]         fv, diff;
    logic                        calc_ok;

    baud_cfg_ctrl_sync_2ff u_sync (
        .clk  (clk),
        .reset(reset),
        .d    (bus.rx_in),
        .q    (rx),
        .rise (rx_rise),
        .fall (rx_fall)
    );

    // Rounded bit period in ticks minus one, plus the low/high symmetry and range checks.
    always_comb begin
        fv      = ((l_q + CNT_BITS'(ROUND)) >> OVS_SHIFT) - CNT_BITS'(1);
        diff    = (l_q >= h_q) ? l_q - h_q : h_q - l_q;
        calc_ok = (diff <= (l_q >> TOL_SHIFT)) && (fv >= FV_MIN) && (fv <= FV_MAX);
    end

    // Next state and registered outputs; gen_rst_n/cfg_update default to their idle levels
    // so a rate change holds the generator in reset for exactly the APPLY cycle.
    always_comb begin
        state_d      = state_q;
        l_d          = l_q;
        h_d          = h_q;
        final_d      = final_q;
        gen_rst_n_d  = 1'b1;
        cfg_update_d = 1'b0;
        busy_d       = busy_q;
        locked_d     = locked_q;
        err_d        = err_q;
        if (bus.host_wr) begin
            state_d      = APPLY;
            final_d      = bus.host_value;
            gen_rst_n_d  = 1'b0;
            cfg_update_d = 1'b1;
            busy_d       = 1'b0;
            locked_d     = 1'b1;
            err_d        = 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (bus.auto_start) begin
                        state_d  = WAIT_IDLE;
                        busy_d   = 1'b1;
                        locked_d = 1'b0;
                        err_d    = 1'b0;
                    end
                end
                WAIT_IDLE: state_d = rx ? WAIT_FALL : WAIT_IDLE;
                WAIT_FALL: begin
                    if (rx_fall) begin
                        l_d     = '0;
                        state_d = MEAS_LOW;
                    end
                end
                MEAS_LOW: begin
                    if (l_q == CNT_MAX) begin
                        err_d   = 1'b1;
                        busy_d  = 1'b0;
                        state_d = IDLE;
                    end else if (rx_rise) begin
                        h_d     = '0;
                        state_d = MEAS_HIGH;
                    end else if (!rx) begin
                        l_d = l_q + 1'b1;
                    end
                end
                MEAS_HIGH: begin
                    if (h_q == CNT_MAX) begin
                        err_d   = 1'b1;
                        busy_d  = 1'b0;
                        state_d = IDLE;
                    end else if (rx_fall) begin
                        state_d = CALC;
                    end else if (rx) begin
                        h_d = h_q + 1'b1;
                    end
                end
                CALC: begin
                    if (calc_ok) begin
                        state_d      = APPLY;
                        final_d      = fv[FINAL_VALUE_BITS-1:0];
                        gen_rst_n_d  = 1'b0;
                        cfg_update_d = 1'b1;
                        busy_d       = 1'b0;
                        locked_d     = 1'b1;
                    end else begin
                        state_d = IDLE;
                        err_d   = 1'b1;
                        busy_d  = 1'b0;
                    end
                end
                APPLY:   state_d = IDLE;
                default: state_d = IDLE;
            endcase
        end
    end

    // State and output registers; reset returns every output to its idle value at once.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q      <= IDLE;
            l_q          <= '0;
            h_q          <= '0;
            final_q      <= DEFAULT_FV;
            gen_rst_n_q  <= 1'b0;
            cfg_update_q <= 1'b0;
            busy_q       <= 1'b0;
            locked_q     <= 1'b0;
            err_q        <= 1'b0;
        end else begin
            state_q      <= state_d;
            l_q          <= l_d;
            h_q          <= h_d;
            final_q      <= final_d;
            gen_rst_n_q  <= gen_rst_n_d;
            cfg_update_q <= cfg_update_d;
            busy_q       <= busy_d;
            locked_q     <= locked_d;
            err_q        <= err_d;
        end
    end

    assign bus.final_value = final_q;
    assign bus.gen_rst_n   = gen_rst_n_q;
    assign bus.cfg_update  = cfg_update_q;
    assign bus.busy        = busy_q;
    assign bus.locked      = locked_q;
    assign bus.err         = err_q;

endmodule

// File: tb/tb_baud_cfg_ctrl.sv
// tb_baud_cfg_ctrl: directed and randomized autobaud/host-write checks against a rate model
module tb_baud_cfg_ctrl;

    logic clk;
    logic reset;
    int   checks;
    int   failures;
    int   exp_fv;

    baud_cfg_ctrl_if #(.FINAL_VALUE_BITS(10)) bus ();

    baud_cfg_ctrl dut (
        .clk  (clk),
        .reset(reset),
        .bus  (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Line is driven synchronously; the fall cycle only restarts the count, so
    // a low run of n clocks measures L = n-1 (same for the high run).
    task automatic run_auto(input string tag, input int lo, input int hi);
        int  l, h, d, fv, n;
        bit  ok;
        l  = lo - 1;
        h  = hi - 1;
        d  = (l > h) ? l - h : h - l;
        fv = (l + 8) / 16 - 1;
        ok = (d <= l / 8) && (fv >= 1) && (fv <= 1023);
        bus.auto_start = 1'b1;
        step();
        bus.auto_start = 1'b0;
        chk({tag, "_busy"}, bus.busy, 1);
        chk({tag, "_unlock"}, bus.locked, 0);
        bus.rx_in = 1'b0;
        repeat (lo) step();
        bus.rx_in = 1'b1;
        repeat (hi) step();
        bus.rx_in = 1'b0;
        n = 0;
        while (bus.busy && n < 50) begin
            step();
            n++;
        end
        chk({tag, "_done"}, bus.busy, 0);
        if (ok) begin
            chk({tag, "_upd"}, bus.cfg_update, 1);
            chk({tag, "_grst"}, bus.gen_rst_n, 0);
            chk({tag, "_fv"}, bus.final_value, fv);
            chk({tag, "_lock"}, bus.locked, 1);
            chk({tag, "_err"}, bus.err, 0);
            exp_fv = fv;
            step();
            chk({tag, "_upd_end"}, bus.cfg_update, 0);
            chk({tag, "_grst_end"}, bus.gen_rst_n, 1);
        end else begin
            chk({tag, "_err"}, bus.err, 1);
            chk({tag, "_fv_kept"}, bus.final_value, exp_fv);
            chk({tag, "_nolock"}, bus.locked, 0);
            chk({tag, "_noupd"}, bus.cfg_update, 0);
        end
        bus.rx_in = 1'b1;
        repeat (4) step();
    endtask

    initial begin
        int n, lo, hi, q, v;
        checks          = 0;
        failures        = 0;
        exp_fv          = 324;
        reset           = 1'b0;
        bus.rx_in       = 1'b1;
        bus.auto_start  = 1'b0;
        bus.host_wr     = 1'b0;
        bus.host_value  = '0;
        repeat (3) step();
        chk("rst_fv", bus.final_value, 324);
        chk("rst_grst", bus.gen_rst_n, 0);
        chk("rst_lock", bus.locked, 0);
        chk("rst_err", bus.err, 0);
        chk("rst_busy", bus.busy, 0);
        reset = 1'b1;
        #1;
        chk("rel_grst_low", bus.gen_rst_n, 0);
        step();
        chk("rel_grst_high", bus.gen_rst_n, 1);
        repeat (4) step();

        run_auto("b9600", 5200, 5200);
        run_auto("r99", 1600, 1600);
        run_auto("tol", 1600, 1900);
        run_auto("tiny", 16, 16);
        for (int i = 0; i < 6; i++) begin
            lo = int'($urandom_range(3000, 200));
            q  = lo / 4;
            hi = lo - q + int'($urandom_range(2 * q, 0));
            run_auto("rand", lo, hi);
        end

        bus.auto_start = 1'b1;
        step();
        bus.auto_start = 1'b0;
        bus.rx_in = 1'b0;
        n = 0;
        while (bus.busy && n < 40000) begin
            step();
            n++;
        end
        chk("sat_busy", bus.busy, 0);
        chk("sat_err", bus.err, 1);
        chk("sat_late", n > 32767 && n < 32800, 1);
        chk("sat_fv", bus.final_value, exp_fv);
        bus.rx_in = 1'b1;
        repeat (4) step();

        bus.auto_start = 1'b1;
        step();
        bus.auto_start = 1'b0;
        bus.rx_in = 1'b0;
        repeat (100) step();
        chk("hw_meas_busy", bus.busy, 1);
        bus.host_wr    = 1'b1;
        bus.host_value = 10'd650;
        bus.auto_start = 1'b1;
        step();
        bus.host_wr    = 1'b0;
        bus.auto_start = 1'b0;
        chk("hw_fv", bus.final_value, 650);
        chk("hw_upd", bus.cfg_update, 1);
        chk("hw_grst", bus.gen_rst_n, 0);
        chk("hw_lock", bus.locked, 1);
        chk("hw_err", bus.err, 0);
        chk("hw_busy", bus.busy, 0);
        step();
        chk("hw_upd_end", bus.cfg_update, 0);
        chk("hw_grst_end", bus.gen_rst_n, 1);
        repeat (5) step();
        chk("hw_aborted", bus.busy, 0);
        bus.rx_in = 1'b1;
        repeat (4) step();

        v = int'($urandom_range(1023, 0));
        bus.host_wr    = 1'b1;
        bus.host_value = 10'(v);
        bus.auto_start = 1'b1;
        step();
        bus.host_wr    = 1'b0;
        bus.auto_start = 1'b0;
        chk("hw_idle_fv", bus.final_value, v);
        chk("hw_idle_busy", bus.busy, 0);
        repeat (3) step();
        chk("hw_idle_noauto", bus.busy, 0);
        chk("hw_idle_lock", bus.locked, 1);

        bus.auto_start = 1'b1;
        step();
        bus.auto_start = 1'b0;
        bus.rx_in = 1'b0;
        repeat (200) step();
        bus.rx_in = 1'b1;
        repeat (100) step();
        reset = 1'b0;
        #1;
        chk("mrst_fv", bus.final_value, 324);
        chk("mrst_grst", bus.gen_rst_n, 0);
        chk("mrst_upd", bus.cfg_update, 0);
        chk("mrst_busy", bus.busy, 0);
        chk("mrst_lock", bus.locked, 0);
        chk("mrst_err", bus.err, 0);
        repeat (2) step();
        reset = 1'b1;
        step();
        chk("mrst_grst_rise", bus.gen_rst_n, 1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
